// File: rtl/wb_xbar_dec.sv
// Single-master Wishbone decoder with registered slave strobe and registered response mux.
// Define WB_XBAR_TIMEOUT_EN to terminate accesses to silent slaves with err_o after TIMEOUT cycles.
module wb_xbar_dec #(
    parameter int                 NUM_SLAVES = 12,
    parameter int                 ADDR_W     = 8,
    parameter int                 SEL_W      = 4,
    parameter int                 DATA_W     = 8,
    parameter int                 TIMEOUT    = 255,
    parameter logic [DATA_W-1:0]  ERR_DATA   = 8'hFF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          stb_i,
    input  logic                          we_i,
    input  logic [ADDR_W-1:0]             adr_i,
    input  logic [DATA_W-1:0]             dat_i,
    output logic [DATA_W-1:0]             dat_o,
    output logic                          ack_o,
    output logic                          err_o,
    output logic                          busy_o,
    output logic [NUM_SLAVES-1:0]         s_stb_o,
    output logic                          s_we_o,
    output logic [ADDR_W-SEL_W-1:0]       s_adr_o,
    output logic [DATA_W-1:0]             s_dat_o,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]         s_ack_i
);
    localparam int OFF_W = ADDR_W - SEL_W;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_chk
        $error("wb_xbar_dec: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [SEL_W-1:0]        w_idx;
    logic [SEL_W-1:0]        r_idx;
    logic                    w_mapped;
    logic                    w_sel_ack;
    logic                    w_timeout;
    logic [DATA_W-1:0]       w_sel_dat;
    logic [NUM_SLAVES-1:0]   w_onehot;

    logic [DATA_W-1:0]       r_dat;
    logic                    r_ack;
    logic                    r_err;
    logic [NUM_SLAVES-1:0]   r_s_stb;
    logic                    r_s_we;
    logic [OFF_W-1:0]        r_s_adr;
    logic [DATA_W-1:0]       r_s_dat;

    assign w_idx    = adr_i[ADDR_W-1 -: SEL_W];
    assign w_mapped = (int'(w_idx) < NUM_SLAVES);

    // Only the latched slave's ack/data are visible; stray acks from others never reach the FSM.
    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_dat = '0;
        w_onehot  = '0;
        for (int n = 0; n < NUM_SLAVES; n++) begin
            if (r_idx == SEL_W'(n)) begin
                w_sel_ack = s_ack_i[n];
                w_sel_dat = s_dat_i[n*DATA_W +: DATA_W];
            end
            w_onehot[n] = (w_idx == SEL_W'(n));
        end
    end

`ifdef WB_XBAR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (r_state == ACTIVE && !w_sel_ack && r_cnt != CNT_W'(TIMEOUT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The edge that takes the counter to TIMEOUT ends the access; an ack at that edge wins.
    assign w_timeout = (r_state == ACTIVE) && !w_sel_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (stb_i) w_next = w_mapped ? ACTIVE : RESP;
            ACTIVE:  if (w_sel_ack || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx   <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_s_stb <= '0;
            r_s_we  <= 1'b0;
            r_s_adr <= '0;
            r_s_dat <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (stb_i) begin
                        r_idx   <= w_idx;
                        r_s_we  <= we_i;
                        r_s_adr <= adr_i[OFF_W-1:0];
                        r_s_dat <= dat_i;
                        if (w_mapped) begin
                            r_s_stb <= w_onehot;
                        end else begin
                            r_err <= 1'b1;
                            r_dat <= ERR_DATA;
                        end
                    end
                end
                ACTIVE: begin
                    if (w_sel_ack) begin
                        r_s_stb <= '0;
                        r_ack   <= 1'b1;
                        r_dat   <= w_sel_dat;
                    end else if (w_timeout) begin
                        r_s_stb <= '0;
                        r_err   <= 1'b1;
                        r_dat   <= ERR_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dat_o   = r_dat;
    assign ack_o   = r_ack;
    assign err_o   = r_err;
    assign busy_o  = (r_state != IDLE);
    assign s_stb_o = r_s_stb;
    assign s_we_o  = r_s_we;
    assign s_adr_o = r_s_adr;
    assign s_dat_o = r_s_dat;

endmodule

// File: tb/tb_wb_xbar_dec.sv
// Directed bench for wb_xbar_dec: decode, response timing, unmapped error, stray acks, reset, timeout.
module tb_wb_xbar_dec;
    logic        clk_i;
    logic        rst_i;
    logic        stb_i;
    logic        we_i;
    logic [7:0]  adr_i;
    logic [7:0]  dat_i;
    logic [7:0]  dat_o;
    logic        ack_o;
    logic        err_o;
    logic        busy_o;
    logic [11:0] s_stb_o;
    logic        s_we_o;
    logic [3:0]  s_adr_o;
    logic [7:0]  s_dat_o;
    logic [95:0] s_dat_i;
    logic [11:0] s_ack_i;

    int checks = 0;
    int errors = 0;

    wb_xbar_dec #(
        .NUM_SLAVES(12), .ADDR_W(8), .SEL_W(4), .DATA_W(8), .TIMEOUT(8), .ERR_DATA(8'hFF)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i),
        .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Returns 1 ns after the next rising edge: registered outputs have settled, inputs may change.
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs;
        stb_i = 1'b0; we_i = 1'b0; adr_i = 8'h00; dat_i = 8'h00;
        s_ack_i = '0; s_dat_i = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_i = 1'b1;
        #3;
        checks++;
        if ({dat_o, ack_o, err_o, busy_o} !== 11'h000) begin
            errors++;
            $display("FAIL reset_master_outs: got dat=%h ack=%b err=%b busy=%b want all 0", dat_o, ack_o, err_o, busy_o);
        end
        checks++;
        if ({s_stb_o, s_we_o, s_adr_o, s_dat_o} !== 25'h0) begin
            errors++;
            $display("FAIL reset_slave_outs: got stb=%h we=%b adr=%h dat=%h want all 0", s_stb_o, s_we_o, s_adr_o, s_dat_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_read_slave3;
        stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h35;
        tick();                                   // cycle 1
        checks++;
        if (s_stb_o !== 12'h008 || s_adr_o !== 4'h5 || s_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rd3_strobe: got stb=%h adr=%h we=%b want 008 5 0", s_stb_o, s_adr_o, s_we_o);
        end
        s_ack_i[3] = 1'b1; s_dat_i[3*8 +: 8] = 8'hA5;
        tick();                                   // cycle 2
        checks++;
        if (ack_o !== 1'b1 || err_o !== 1'b0 || dat_o !== 8'hA5 || s_stb_o !== 12'h000) begin
            errors++;
            $display("FAIL rd3_ack: got ack=%b err=%b dat=%h stb=%h want 1 0 a5 000", ack_o, err_o, dat_o, s_stb_o);
        end
        stb_i = 1'b0; s_ack_i = '0;
        tick();                                   // cycle 3
        checks++;
        if (busy_o !== 1'b0 || ack_o !== 1'b0) begin
            errors++;
            $display("FAIL rd3_done: got busy=%b ack=%b want 0 0", busy_o, ack_o);
        end
    endtask

    task automatic test_write_slave11;
        int acks;
        int held_bad;
        acks = 0; held_bad = 0;
        stb_i = 1'b1; we_i = 1'b1; adr_i = 8'hB2; dat_i = 8'h3C;
        tick();                                   // cycle 1
        stb_i = 1'b0; we_i = 1'b0; adr_i = 8'h00; dat_i = 8'hC3;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 5 && (s_stb_o !== 12'h800 || s_we_o !== 1'b1 || s_dat_o !== 8'h3C || s_adr_o !== 4'h2))
                held_bad++;
            if (ack_o === 1'b1) begin
                acks++;
                checks++;
                if (c !== 6 || dat_o !== 8'h77) begin
                    errors++;
                    $display("FAIL wr11_ack_timing: got cycle=%0d dat=%h want cycle 6 dat 77", c, dat_o);
                end
            end
            if (c == 5) begin
                s_ack_i[11] = 1'b1; s_dat_i[11*8 +: 8] = 8'h77;
            end else begin
                s_ack_i = '0;
            end
            tick();
        end
        checks++;
        if (held_bad !== 0) begin
            errors++;
            $display("FAIL wr11_held: got %0d unstable strobe cycles want 0", held_bad);
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL wr11_ack_count: got %0d ack pulses want 1", acks);
        end
        checks++;
        if (s_we_o !== 1'b1 || s_dat_o !== 8'h3C || s_stb_o !== 12'h000) begin
            errors++;
            $display("FAIL wr11_after: got we=%b dat=%h stb=%h want 1 3c 000", s_we_o, s_dat_o, s_stb_o);
        end
    endtask

    task automatic test_unmapped;
        stb_i = 1'b1; we_i = 1'b0; adr_i = 8'hE0;
        tick();                                   // cycle 1
        checks++;
        if (err_o !== 1'b1 || ack_o !== 1'b0 || dat_o !== 8'hFF || s_stb_o !== 12'h000) begin
            errors++;
            $display("FAIL unmapped_err: got err=%b ack=%b dat=%h stb=%h want 1 0 ff 000", err_o, ack_o, dat_o, s_stb_o);
        end
        stb_i = 1'b0;
        tick();                                   // cycle 2
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_done: got err=%b busy=%b want 0 0", err_o, busy_o);
        end
    endtask

    task automatic test_stray_ack;
        int early;
        early = 0;
        stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h21;
        tick();                                   // cycle 1
        stb_i = 1'b0;
        s_ack_i[5] = 1'b1; s_dat_i[5*8 +: 8] = 8'h55; s_dat_i[2*8 +: 8] = 8'h5A;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (ack_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b1 || s_stb_o !== 12'h004) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL stray_ignored: got %0d cycles reacting to slave 5 want 0", early);
        end
        s_ack_i[2] = 1'b1;                        // cycle 4
        tick();                                   // cycle 5
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 8'h5A) begin
            errors++;
            $display("FAIL stray_complete: got ack=%b dat=%h want 1 5a", ack_o, dat_o);
        end
        s_ack_i = '0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [5:0] ack_seen;
        logic [5:0] busy_seen;
        logic [5:0] ack_want;
        logic [5:0] busy_want;
        ack_want  = 6'b010010;                    // bit c-1 = cycle c
        busy_want = 6'b011011;
        stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h35;
        s_ack_i[3] = 1'b1; s_dat_i[3*8 +: 8] = 8'h3E;
        for (int c = 1; c <= 6; c++) begin
            tick();
            ack_seen[c-1]  = ack_o;
            busy_seen[c-1] = busy_o;
        end
        stb_i = 1'b0; s_ack_i = '0;
        checks++;
        if (ack_seen !== ack_want) begin
            errors++;
            $display("FAIL b2b_ack: got %b want %b", ack_seen, ack_want);
        end
        checks++;
        if (busy_seen !== busy_want) begin
            errors++;
            $display("FAIL b2b_busy: got %b want %b", busy_seen, busy_want);
        end
        tick(); tick();
    endtask

`ifdef WB_XBAR_TIMEOUT_EN
    task automatic test_timeout;
        int bad;
        bad = 0;
        stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h00;
        tick();                                   // cycle 1
        stb_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (s_stb_o !== 12'h001 || err_o !== 1'b0 || ack_o !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL to_strobe: got %0d bad cycles in 1..8 want 0", bad);
        end
        checks++;                                 // cycle 9
        if (err_o !== 1'b1 || ack_o !== 1'b0 || dat_o !== 8'hFF || s_stb_o !== 12'h000) begin
            errors++;
            $display("FAIL to_err: got err=%b ack=%b dat=%h stb=%h want 1 0 ff 000", err_o, ack_o, dat_o, s_stb_o);
        end
        tick();
        stb_i = 1'b1; adr_i = 8'h00;
        tick();                                   // cycle 1
        stb_i = 1'b0;
        for (int c = 1; c <= 7; c++) tick();
        s_ack_i[0] = 1'b1; s_dat_i[7:0] = 8'h42;  // cycle 8
        tick();                                   // cycle 9
        checks++;
        if (ack_o !== 1'b1 || err_o !== 1'b0 || dat_o !== 8'h42) begin
            errors++;
            $display("FAIL to_ack_wins: got ack=%b err=%b dat=%h want 1 0 42", ack_o, err_o, dat_o);
        end
        s_ack_i = '0;
        tick();
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL to_ack_after: got err=%b busy=%b want 0 0", err_o, busy_o);
        end
    endtask
`else
    task automatic test_timeout;
        int bad;
        bad = 0;
        stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h00;
        tick();
        stb_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (s_stb_o !== 12'h001 || err_o !== 1'b0 || ack_o !== 1'b0 || busy_o !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL no_timeout_wait: got %0d cycles not waiting want 0", bad);
        end
        #2 rst_i = 1'b1;
        #2 rst_i = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid_active;
        stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h13; dat_i = 8'h99;
        tick();                                   // cycle 1, ACTIVE on slave 1
        stb_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({dat_o, ack_o, err_o, busy_o, s_stb_o, s_we_o, s_adr_o, s_dat_o} !== 36'h0) begin
            errors++;
            $display("FAIL mid_reset: got dat=%h busy=%b stb=%h we=%b adr=%h sdat=%h want all 0",
                     dat_o, busy_o, s_stb_o, s_we_o, s_adr_o, s_dat_o);
        end
        #2 rst_i = 1'b0;
        stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h47;
        tick();                                   // cycle 1
        checks++;
        if (s_stb_o !== 12'h010 || s_adr_o !== 4'h7) begin
            errors++;
            $display("FAIL post_reset_strobe: got stb=%h adr=%h want 010 7", s_stb_o, s_adr_o);
        end
        stb_i = 1'b0;
        s_ack_i[4] = 1'b1; s_dat_i[4*8 +: 8] = 8'hC3;
        tick();                                   // cycle 2
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 8'hC3) begin
            errors++;
            $display("FAIL post_reset_ack: got ack=%b dat=%h want 1 c3", ack_o, dat_o);
        end
        s_ack_i = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_slave3();
        test_write_slave11();
        test_unmapped();
        test_stray_ack();
        test_back_to_back();
        test_timeout();
        test_reset_mid_active();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
